// File: rtl/escritor_rtc.sv
// Write sequencer for the RTC multiplexed A/D port: address phase, then data phase,
// then a one-cycle fin pulse. Outputs are registered from the current state (one cycle behind it).
module escritor_rtc #(
   parameter int T_SETUP = 2,
   parameter int T_PULSE = 10,
   parameter int T_HOLD  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       escribe,
   input  logic [7:0] dir_in,
   input  logic [7:0] dato_in,
   output logic [7:0] ad_out,
   output logic       ad_oe,
   output logic       ad_sel,
   output logic       cs_n,
   output logic       wr_n,
   output logic       rd_n,
   output logic       busy,
   output logic       fin
);

   localparam logic [3:0] IDLE     = 4'd0;
   localparam logic [3:0] A_SET    = 4'd1;
   localparam logic [3:0] A_WR     = 4'd2;
   localparam logic [3:0] A_HLD    = 4'd3;
   localparam logic [3:0] D_SET    = 4'd4;
   localparam logic [3:0] D_WR     = 4'd5;
   localparam logic [3:0] D_HLD    = 4'd6;
   localparam logic [3:0] DONE     = 4'd7;
   localparam logic [3:0] WAIT_LOW = 4'd8;

   localparam logic [7:0] SET_L = 8'(T_SETUP - 1);
   localparam logic [7:0] WR_L  = 8'(T_PULSE - 1);
   localparam logic [7:0] HLD_L = 8'(T_HOLD - 1);

   logic [3:0] state, nxt;
   logic [7:0] cnt;
   logic [7:0] dir_r, dato_r;
   logic       skip_q, skip_d;
   logic       in_a, in_d;

   // A zero address skips the bus entirely; the extra skip cycle keeps fin two edges after capture.
   always_comb begin
      nxt    = state;
      skip_d = 1'b0;
      case (state)
         IDLE: begin
            if (skip_q)
               nxt = DONE;
            else if (escribe && dir_in != 8'h00)
               nxt = A_SET;
            else if (escribe)
               skip_d = 1'b1;
         end
         A_SET:    if (cnt == SET_L) nxt = A_WR;
         A_WR:     if (cnt == WR_L)  nxt = A_HLD;
         A_HLD:    if (cnt == HLD_L) nxt = D_SET;
         D_SET:    if (cnt == SET_L) nxt = D_WR;
         D_WR:     if (cnt == WR_L)  nxt = D_HLD;
         D_HLD:    if (cnt == HLD_L) nxt = DONE;
         DONE:     nxt = WAIT_LOW;
         WAIT_LOW: if (!escribe) nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   assign in_a = (state == A_SET) || (state == A_WR) || (state == A_HLD);
   assign in_d = (state == D_SET) || (state == D_WR) || (state == D_HLD);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= 8'h00;
         dir_r  <= 8'h00;
         dato_r <= 8'h00;
         skip_q <= 1'b0;
         ad_out <= 8'h00;
         ad_oe  <= 1'b0;
         ad_sel <= 1'b0;
         cs_n   <= 1'b1;
         wr_n   <= 1'b1;
         rd_n   <= 1'b1;
         busy   <= 1'b0;
         fin    <= 1'b0;
      end else begin
         state  <= nxt;
         skip_q <= skip_d;
         cnt    <= (nxt != state || !(in_a || in_d)) ? 8'h00 : cnt + 8'h01;
         if (state == IDLE && escribe && !skip_q && dir_in != 8'h00) begin
            dir_r  <= dir_in;
            dato_r <= dato_in;
         end
         // cs_n/ad_oe cover all six phase states, so nothing toggles between address and data.
         ad_out <= in_a ? dir_r : (in_d ? dato_r : 8'h00);
         ad_oe  <= in_a || in_d;
         ad_sel <= in_d;
         cs_n   <= !(in_a || in_d);
         wr_n   <= !(state == A_WR || state == D_WR);
         rd_n   <= 1'b1;
         busy   <= skip_q || (state != IDLE && state != WAIT_LOW);
         fin    <= (state == DONE);
      end
   end

endmodule

// File: tb/tb_escritor_rtc.sv
// Directed bench for escritor_rtc: reset, single write, stale request, skip, mid-op reset, sequence.
module tb_escritor_rtc;

   logic       clk = 1'b0;
   logic       reset, escribe;
   logic [7:0] dir_in, dato_in;
   logic [7:0] ad_out;
   logic       ad_oe, ad_sel, cs_n, wr_n, rd_n, busy, fin;

   int n_chk = 0;
   int n_err = 0;
   int viol  = 0;
   logic       wr_prev = 1'b1;
   logic [8:0] mon_q[$];

   escritor_rtc dut (
      .clk(clk), .reset(reset), .escribe(escribe), .dir_in(dir_in), .dato_in(dato_in),
      .ad_out(ad_out), .ad_oe(ad_oe), .ad_sel(ad_sel), .cs_n(cs_n), .wr_n(wr_n),
      .rd_n(rd_n), .busy(busy), .fin(fin)
   );

   always #5 clk = ~clk;

   // Bus monitor: log {ad_sel, ad_out} at every falling write strobe; flag unsafe strobes.
   always @(negedge clk) begin
      if (!wr_n && (!ad_oe || cs_n)) viol++;
      if (wr_prev && !wr_n) mon_q.push_back({ad_sel, ad_out});
      wr_prev = wr_n;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called just after a negedge; capture edge is the next posedge (edge 0).
   task automatic run_xfer(input logic [7:0] d, input logic [7:0] v, input bit scramble,
                           output int lat, output int lo_a, output int lo_d, output int act);
      lat = -1; lo_a = 0; lo_d = 0; act = 0;
      dir_in = d; dato_in = v; escribe = 1'b1;
      for (int e = 0; e < 100; e++) begin
         @(posedge clk); #1;
         if (scramble && e == 0) begin dir_in = 8'hEE; dato_in = 8'hDD; end
         if (!wr_n && !ad_sel && ad_out == d) lo_a++;
         if (!wr_n &&  ad_sel && ad_out == v) lo_d++;
         if (!cs_n || !wr_n) act++;
         if (fin) begin lat = e; break; end
      end
   endtask

   int lat, lo_a, lo_d, act, bad;
   logic [7:0] seq_a[10];

   initial begin
      seq_a = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h41, 8'h42, 8'h43};
      reset = 1'b0; escribe = 1'b1; dir_in = 8'h21; dato_in = 8'h15;

      // 1. reset held with escribe high
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("reset_out%0d", i),
             {ad_out, ad_oe, ad_sel, cs_n, wr_n, rd_n, busy, fin}, {8'h00, 7'b0011100});
      end
      @(negedge clk); escribe = 1'b0; reset = 1'b1;
      @(negedge clk);

      // 2. single write, inputs scrambled after capture
      run_xfer(8'h21, 8'h15, 1'b1, lat, lo_a, lo_d, act);
      chk("wr_latency", lat, 29);
      chk("wr_addr_low", lo_a, 10);
      chk("wr_data_low", lo_d, 10);
      chk("wr_busy_at_fin", busy, 1);
      @(posedge clk); #1;
      chk("fin_one_cycle", {fin, busy}, 2'b00);

      // 3. stale request stays blocked
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (fin || !cs_n || busy) bad++;
      end
      chk("stale_blocked", bad, 0);
      @(negedge clk); escribe = 1'b0;
      @(negedge clk);
      run_xfer(8'h22, 8'h5A, 1'b0, lat, lo_a, lo_d, act);
      chk("retrig_latency", lat, 29);
      chk("retrig_data_low", lo_d, 10);
      @(negedge clk); escribe = 1'b0;
      @(negedge clk);

      // 4. zero address skip
      run_xfer(8'h00, 8'h99, 1'b0, lat, lo_a, lo_d, act);
      chk("skip_latency", lat, 2);
      chk("skip_no_bus", act, 0);
      @(negedge clk); escribe = 1'b0;
      @(negedge clk);

      // 5. reset during D_WR
      dir_in = 8'h24; dato_in = 8'h33; escribe = 1'b1;
      lat = -1;
      for (int e = 0; e < 100; e++) begin
         @(negedge clk);
         if (!wr_n && ad_sel) begin lat = e; break; end
      end
      chk("reach_d_wr", int'(lat > 0), 1);
      reset = 1'b0; escribe = 1'b0;
      @(posedge clk); #1;
      chk("midrst_bus", {wr_n, cs_n, ad_oe, fin, busy}, 5'b11000);
      @(posedge clk); #1;
      chk("midrst_nofin", fin, 0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      run_xfer(8'h43, 8'h07, 1'b0, lat, lo_a, lo_d, act);
      chk("post_rst_latency", lat, 29);
      chk("post_rst_low", lo_a + lo_d, 20);
      @(negedge clk); escribe = 1'b0;
      @(negedge clk);

      // 6. handshake sequence of ten registers
      mon_q.delete();
      for (int i = 0; i < 10; i++) begin
         run_xfer(seq_a[i], 8'h30 + 8'(i), 1'b0, lat, lo_a, lo_d, act);
         if (lat != 29) chk($sformatf("seq_lat%0d", i), lat, 29);
         @(negedge clk); escribe = 1'b0;
         @(negedge clk);
      end
      chk("seq_count", mon_q.size(), 20);
      for (int i = 0; i < 10 && 2*i+1 < mon_q.size(); i++) begin
         chk($sformatf("seq_addr%0d", i), mon_q[2*i],   {1'b0, seq_a[i]});
         chk($sformatf("seq_data%0d", i), mon_q[2*i+1], {1'b1, 8'h30 + 8'(i)});
      end
      chk("strobe_safety", viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
